// File: rtl/iurt_dwn_fifo.sv
// IURT downstream byte FIFO.
// Buffers host-to-target bytes from the IPDBG hub down channel and releases
// them one at a time as single-cycle strobes toward the IURT controller.
// After each strobe a two-cycle holdoff masks the controller's registered
// ready, which is still high for one cycle after it has seen the strobe.
module iurt_dwn_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clr_ovf
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    // Holdoff countdown after an issue: two masked cycles, then idle.
    typedef enum logic [1:0] {
        HOLD_IDLE = 2'd0,
        HOLD_1    = 2'd1,
        HOLD_2    = 2'd2
    } hold_e;

    hold_e hold_q, hold_d;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  out_valid_q, out_valid_d;
    logic [7:0]            out_data_q, out_data_d;
    logic                  overflow_q, overflow_d;

    logic full;
    logic empty;
    logic wr_en;
    logic drop;
    logic issue;

    assign full  = (level_q == LEVEL_FULL);
    assign empty = (level_q == '0);

    // Write acceptance depends only on the level before this cycle, so a
    // same-cycle issue never frees a slot for a write into a full buffer.
    assign wr_en = ce & in_valid & ~full;
    assign drop  = ce & in_valid & full;
    assign issue = ce & ~empty & out_ready & (hold_q == HOLD_IDLE);

    // Holdoff next state: load on issue, otherwise count down toward idle.
    always_comb begin
        hold_d = hold_q;
        if (ce) begin
            if (issue) begin
                hold_d = HOLD_2;
            end else begin
                unique case (hold_q)
                    HOLD_2:  hold_d = HOLD_1;
                    HOLD_1:  hold_d = HOLD_IDLE;
                    default: hold_d = HOLD_IDLE;
                endcase
            end
        end
    end

    // Holdoff state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q <= HOLD_IDLE;
        end else begin
            hold_q <= hold_d;
        end
    end

    // Pointer, occupancy, output strobe and overflow next-state logic.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        overflow_d  = overflow_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (ce) begin
            out_valid_d = issue;
        end

        if (issue) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            out_data_d = mem_q[rd_ptr_q];
        end

        unique case ({wr_en, issue})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ce && clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
        end
    end

    // Byte storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready  = ~full;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_iurt_dwn_fifo.sv
module tb_iurt_dwn_fifo;

    localparam int unsigned DL2   = 4;
    localparam int          DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           ce = 1'b1;
    logic           in_valid = 1'b0;
    logic [7:0]     in_data = 8'h00;
    logic           in_ready;
    logic           out_valid;
    logic [7:0]     out_data;
    logic           out_ready = 1'b0;
    logic [DL2:0]   level;
    logic           overflow;
    logic           clr_ovf = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    iurt_dwn_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    // Reference model: queue of stored bytes, holdoff counter, strobe and flag.
    logic [7:0] mq[$];
    int         m_hold = 0;
    bit         m_ov = 1'b0;
    logic [7:0] m_od = 8'h00;
    bit         m_ovf = 1'b0;

    task automatic model_step();
        bit was_full;
        bit go;
        if (!rst) begin
            mq.delete();
            m_hold = 0;
            m_ov   = 1'b0;
            m_ovf  = 1'b0;
        end else if (ce) begin
            was_full = (mq.size() == DEPTH);
            go = (mq.size() != 0) && out_ready && (m_hold == 0);
            if (go) begin
                m_od   = mq.pop_front();
                m_ov   = 1'b1;
                m_hold = 2;
            end else begin
                m_ov = 1'b0;
                if (m_hold > 0) m_hold = m_hold - 1;
            end
            if (in_valid && !was_full) mq.push_back(in_data);
            if (in_valid && was_full) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Output byte monitor.
    logic [7:0] got[$];
    bit         mon_en = 1'b0;

    initial forever begin
        @(negedge clk);
        if (mon_en && out_valid === 1'b1) got.push_back(out_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        rst = 1'b1;
    endtask

    task automatic test_single_byte();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h41;
        tick();
        total++; if (level !== 5'd1) begin bad++; $display("FAIL single_level1 got=%0d want=1", level); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", out_valid); end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 8'h41) begin bad++; $display("FAIL single_data got=%h want=41", out_data); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL single_level0 got=%0d want=0", level); end
        repeat (5) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_extra_pulse got=%b want=0", out_valid); end
        end
    endtask

    task automatic test_burst();
        int n = 0;
        int last = 0;
        idle(4);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 120 && n < 16; cyc++) begin
            if (cyc < 16) begin
                in_valid = 1'b1; in_data = 8'(cyc);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            total++; if (level > 5'd16) begin bad++; $display("FAIL burst_level got=%0d want<=16", level); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL burst_in_ready got=%b want=1", in_ready); end
            if (out_valid === 1'b1) begin
                total++; if (out_data !== 8'(n)) begin bad++; $display("FAIL burst_data got=%h want=%h", out_data, 8'(n)); end
                if (n > 0) begin
                    total++; if (cyc - last != 3) begin bad++; $display("FAIL burst_spacing got=%0d want=3", cyc - last); end
                end
                last = cyc;
                n++;
            end
        end
        in_valid = 1'b0;
        total++; if (n != 16) begin bad++; $display("FAIL burst_count got=%0d want=16", n); end
        repeat (6) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL burst_extra_pulse got=%b want=0", out_valid); end
        end
    endtask

    task automatic test_overflow();
        int n = 0;
        idle(4);
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(i);
            tick();
            if (i == 15) begin
                total++; if (level !== 5'd16) begin bad++; $display("FAIL ovf_level_full got=%0d want=16", level); end
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ovf_in_ready got=%b want=0", in_ready); end
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", overflow); end
            end
        end
        total++; if (level !== 5'd16) begin bad++; $display("FAIL ovf_level_after_drop got=%0d want=16", level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && n < 16; cyc++) begin
            tick();
            if (out_valid === 1'b1) begin
                total++; if (out_data !== 8'h10 + 8'(n)) begin bad++; $display("FAIL ovf_drain_data got=%h want=%h", out_data, 8'h10 + 8'(n)); end
                n++;
            end
        end
        total++; if (n != 16) begin bad++; $display("FAIL ovf_drain_count got=%0d want=16", n); end
        tick();
        total++; if (level !== 5'd0) begin bad++; $display("FAIL ovf_drained_level got=%0d want=0", level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    endtask

    task automatic test_controller();
        int n = 0;
        int wait_cnt = 0;
        int post = 0;
        bit drop_next = 1'b0;
        bit awaiting = 1'b0;
        logic [DL2:0] exp_lvl;
        idle(4);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && post < 6; cyc++) begin
            if (cyc < 3) begin
                in_valid = 1'b1; in_data = 8'hA1 + 8'(cyc);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            exp_lvl = (DL2 + 1)'(mq.size());
            total++; if (out_valid !== m_ov) begin bad++; $display("FAIL ctrl_valid got=%b want=%b", out_valid, m_ov); end
            total++; if (level !== exp_lvl) begin bad++; $display("FAIL ctrl_level got=%0d want=%0d", level, exp_lvl); end
            if (drop_next) begin
                out_ready = 1'b0; drop_next = 1'b0;
                wait_cnt = $urandom_range(2, 6);
            end else if (!out_ready) begin
                wait_cnt--;
                if (wait_cnt == 0) begin out_ready = 1'b1; awaiting = 1'b0; end
            end
            if (out_valid === 1'b1) begin
                total++; if (awaiting) begin bad++; $display("FAIL ctrl_before_ack got=1 want=0"); end
                total++; if (out_data !== 8'hA1 + 8'(n)) begin bad++; $display("FAIL ctrl_data got=%h want=%h", out_data, 8'hA1 + 8'(n)); end
                n++; awaiting = 1'b1; drop_next = 1'b1;
            end
            if (n == 3 && !awaiting) post++;
        end
        total++; if (n != 3) begin bad++; $display("FAIL ctrl_count got=%0d want=3", n); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] sent[$];
        int w = 0;
        idle(4);
        got.delete();
        mon_en = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom); sent.push_back(in_data);
            tick();
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && w < 20; cyc++) begin
            if (mq.size() != 0 && m_hold == 0) begin
                in_valid = 1'b1; in_data = 8'($urandom); sent.push_back(in_data); w++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            total++; if (level !== 5'd3) begin bad++; $display("FAIL simul_level got=%0d want=3", level); end
        end
        total++; if (w != 20) begin bad++; $display("FAIL simul_writes got=%0d want=20", w); end
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom); sent.push_back(in_data);
            tick();
        end
        total++; if (level !== 5'd16) begin bad++; $display("FAIL simul_full got=%0d want=16", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL simul_ovf_pre got=%b want=0", overflow); end
        in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1; clr_ovf = 1'b1;
        tick();
        in_valid = 1'b0; clr_ovf = 1'b0;
        total++; if (level !== 5'd15) begin bad++; $display("FAIL simul_full_issue_level got=%0d want=15", level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL simul_set_wins got=%b want=1", overflow); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL simul_in_ready got=%b want=1", in_ready); end
        repeat (60) tick();
        mon_en = 1'b0;
        total++; if (got.size() != sent.size()) begin bad++; $display("FAIL simul_out_count got=%0d want=%0d", got.size(), sent.size()); end
        for (int i = 0; i < sent.size() && i < got.size(); i++) begin
            total++; if (got[i] !== sent[i]) begin bad++; $display("FAIL simul_order[%0d] got=%h want=%h", i, got[i], sent[i]); end
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
    endtask

    task automatic test_reset_ce();
        idle(4);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 8'h60 + 8'(i);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        total++; if (level !== 5'd5) begin bad++; $display("FAIL rce_level5 got=%0d want=5", level); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rce_valid_hi got=%b want=1", out_valid); end
        out_ready = 1'b0; ce = 1'b0; rst = 1'b0;
        tick();
        total++; if (level !== 5'd0) begin bad++; $display("FAIL rce_rst_level got=%0d want=0", level); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rce_rst_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rce_rst_in_ready got=%b want=1", in_ready); end
        rst = 1'b1; ce = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 8'h70 + 8'(i);
            tick();
        end
        ce = 1'b0; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        repeat (4) begin
            tick();
            total++; if (level !== 5'd2) begin bad++; $display("FAIL rce_ce_hold_level got=%0d want=2", level); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rce_ce_hold_valid got=%b want=0", out_valid); end
        end
        ce = 1'b1; in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rce_issue_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 8'h70) begin bad++; $display("FAIL rce_issue_data got=%h want=70", out_data); end
        ce = 1'b0;
        repeat (3) begin
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rce_valid_hold got=%b want=1", out_valid); end
            total++; if (level !== 5'd1) begin bad++; $display("FAIL rce_level_hold got=%0d want=1", level); end
        end
        ce = 1'b1;
        idle(8);
        total++; if (level !== 5'd0) begin bad++; $display("FAIL rce_final_level got=%0d want=0", level); end
    endtask

    task automatic test_random();
        logic [DL2:0] exp_lvl;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst       = ($urandom_range(0, 99) != 0);
            ce        = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 1) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            clr_ovf   = ($urandom_range(0, 19) == 0);
            tick();
            exp_lvl = (DL2 + 1)'(mq.size());
            total++; if (level !== exp_lvl) begin bad++; $display("FAIL rand_level cyc=%0d got=%0d want=%0d", cyc, level, exp_lvl); end
            total++; if (in_ready !== (mq.size() != DEPTH)) begin bad++; $display("FAIL rand_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, mq.size() != DEPTH); end
            total++; if (out_valid !== m_ov) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", cyc, out_valid, m_ov); end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rand_overflow cyc=%0d got=%b want=%b", cyc, overflow, m_ovf); end
            if (m_ov) begin
                total++; if (out_data !== m_od) begin bad++; $display("FAIL rand_data cyc=%0d got=%h want=%h", cyc, out_data, m_od); end
            end
        end
        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; clr_ovf = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_overflow();
        test_controller();
        test_simultaneous();
        test_reset_ce();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
